// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
//   Shared pipeline definitions for the EX-stage multiply/divide unit:
//   the 3-bit mul/div/HI-LO op encodings and the iterative FSM state type.
//   Also provides a small helper that takes the magnitude of a value that
//   may be treated as signed.

package ex_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Magnitude of a 32-bit value; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] value, input logic is_neg);
        return is_neg ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv
//   Iterative MIPS-style HI/LO multiply/divide unit for the EX stage.
//   MULT/MULTU/DIV/DIVU take 32 CALC cycles plus one FIX cycle; the unit
//   stalls the front of the pipeline while busy.  MFHI/MFLO read HI/LO
//   combinationally, MTHI/MTLO write them at the next edge.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      EX instruction is a mul/div/HI-LO op this cycle
//   flush      kill the EX instruction this cycle (start ignored)
//   op         operation encoding (see ex_muldiv_pkg)
//   op1, op2   forwarded rs / rt operands
//   stall      hold PC, IF/ID and ID/EX (combinational)
//   mf_result  HI or LO for MFHI/MFLO (combinational)
//   hi_o, lo_o architectural HI/LO registers
//   done       one-cycle pulse after a mul/div wrote HI/LO

module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        stall,
    output logic [31:0] mf_result,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done
);

    muldiv_state_t state, state_next;

    logic [63:0] acc;
    logic [31:0] operand;
    logic [4:0]  counter;
    logic        is_div;
    logic        neg_quot;
    logic        neg_rem;

    logic        issue;
    logic        accept;
    logic        mt_write;
    logic        signed_op;
    logic        neg_a;
    logic        neg_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] product;

    assign issue     = start && !flush && (state == IDLE);
    assign accept    = issue && (op[2] == 1'b0);
    assign mt_write  = issue && ((op == OP_MTHI) || (op == OP_MTLO));
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign neg_a     = signed_op && op1[31];
    assign neg_b     = signed_op && op2[31];

    // Shift-add multiply: multiplier sits in acc[31:0] and is consumed LSB
    // first while the partial product grows into the upper half.  The carry
    // of the add becomes the new MSB after the right shift.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Restoring divide: the partial remainder is shifted left one bit into a
    // 33-bit window; a borrow (bit 32 set) means the divisor did not fit.
    // With a zero divisor every step "fits", giving quotient all-ones and the
    // dividend magnitude as remainder.
    assign div_diff = acc[63:31] - {1'b0, operand};
    assign div_next = div_diff[32] ? {acc[62:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    assign product = neg_quot ? (64'd0 - acc) : acc;

    assign stall = (state != IDLE) || accept;

    always_comb begin
        mf_result = 32'd0;
        if (state == IDLE) begin
            if (op == OP_MFHI) begin
                mf_result = hi_o;
            end else if (op == OP_MFLO) begin
                mf_result = lo_o;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (counter == 5'd0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= 64'd0;
            operand  <= 32'd0;
            counter  <= 5'd0;
            is_div   <= 1'b0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= {32'd0, mag32(op1, neg_a)};
                        operand  <= mag32(op2, neg_b);
                        counter  <= 5'd31;
                        is_div   <= op[1];
                        neg_quot <= neg_a ^ neg_b;
                        neg_rem  <= neg_a;
                    end else if (mt_write) begin
                        if (op == OP_MTHI) begin
                            hi_o <= op1;
                        end else begin
                            lo_o <= op1;
                        end
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    if (counter != 5'd0) begin
                        counter <= counter - 5'd1;
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // Remainder keeps the dividend sign; divide-by-zero
                        // therefore returns op1 in HI unchanged.
                        hi_o <= neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
                        if (operand == 32'd0) begin
                            lo_o <= 32'hFFFF_FFFF;
                        end else begin
                            lo_o <= neg_quot ? (32'd0 - acc[31:0]) : acc[31:0];
                        end
                    end else begin
                        hi_o <= product[63:32];
                        lo_o <= product[31:0];
                    end
                end
                default: begin
                    counter <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset; clock clk.
REQ-003 SHALL have port: start  input  1  EX-stage instruction valid with a mul/div/HI-LO op this cycle.
REQ-004 SHALL have port: flush  input  1  kill the EX instruction this cycle; start is ignored.
REQ-005 SHALL have port: op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
REQ-006 SHALL have port: op1  input  32  forwarded rs operand (multiplicand/dividend/MT source).
REQ-007 SHALL have port: op2  input  32  forwarded rt operand (multiplier/divisor).
REQ-008 SHALL have port: stall  output  1  hold PC, IF/ID and ID/EX; combinational.
REQ-009 SHALL have port: mf_result  output  32  HI or LO for MFHI/MFLO; combinational.
REQ-010 SHALL have port: hi_o, lo_o  output  32 each  architectural HI/LO registers.
REQ-011 SHALL have port: done  output  1  registered one-cycle pulse after HI/LO written by a mul/div.

Function
REQ-012 SHALL use FSM states IDLE, CALC, FIX; reset state IDLE.
REQ-013 SHALL treat start&&!flush&&op<=3 in IDLE as accept: latch operand magnitudes and sign flags, counter=31, go CALC.
REQ-014 SHALL iterate one shift-add (mult) or restoring shift-subtract (div) step per CALC cycle; counter decrements; CALC->FIX when counter==0 (32 CALC cycles, no wrap).
REQ-015 SHALL in FIX apply sign correction, write HI/LO, pulse done next cycle, go IDLE.
REQ-016 SHALL, for accept at edge E0, update HI/LO at edge E0+33 and assert done during cycle E0+33..E0+34.
REQ-017 SHALL, for MULT/MULTU, produce 64-bit product: HI=[63:32], LO=[31:0]; MULT negates product when operand signs differ.
REQ-018 SHALL, for DIV/DIVU, set LO=quotient, HI=remainder; DIV quotient negative if signs differ, remainder takes dividend sign.
REQ-019 SHALL, for divisor 0 (DIV or DIVU), set LO=0xFFFFFFFF, HI=op1, same 33-cycle latency.
REQ-020 SHALL, for DIV 0x80000000/0xFFFFFFFF, set LO=0x80000000, HI=0.
REQ-021 SHALL drive stall=1 when state!=IDLE, or when start&&!flush&&op<=5 in IDLE with a mul/div accept that cycle (op<=3).
REQ-022 SHALL drive stall=1 for MFHI/MFLO (start&&!flush) whenever state!=IDLE; mf_result valid only when stall=0.
REQ-023 SHALL in IDLE drive mf_result=hi_o for MFHI, lo_o for MFLO, else 0.
REQ-024 SHALL write op1 to HI (MTHI) or LO (MTLO) at next edge when start&&!flush in IDLE; no stall; ignored while busy (upstream held by stall).
REQ-025 SHALL ignore start while state!=IDLE; flush while busy does not abort the in-progress op.
REQ-026 SHALL make MFHI in the cycle after MTHI return the new value.

Reset
REQ-027 SHALL on reset (any state, including mid-CALC) set state IDLE, counter 0, HI=LO=0, done=0, internal accumulators 0; stall follows REQ-021 immediately.
REQ-028 SHALL discard any in-progress result on reset; no done pulse follows.

Structure
REQ-029 SHALL take op encodings (3-bit constants) and FSM state typedef from the shared pipeline package.
REQ-030 SHALL be a single module; no sub-module; one 64-bit accumulator, one 32-bit operand register, 5-bit counter.

Verification
REQ-031 SHALL test MULT op1=7, op2=0xFFFFFFFD -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB, done one pulse, stall high 33 cycles.
REQ-032 SHALL test DIVU 100/7 -> LO=14, HI=2; DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 SHALL test DIVU 5/0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 SHALL test reset asserted at CALC cycle 10 -> state IDLE, HI=LO=0, stall=0, no done.
REQ-035 SHALL test MTHI 0x12345678 then MFHI next cycle -> mf_result=0x12345678, stall=0; MFLO issued during MULT -> stall until done, then mf_result=new LO.
REQ-036 SHALL test start=1, flush=1, op=MULTU -> no accept, stall=0, HI/LO unchanged.
